// File: rtl/pc_seq_stage_if.sv
// pc_seq_stage_if: control, operand and status bundle for the PC sequencing stage
interface pc_seq_stage_if;
  logic        start;
  logic        step;
  logic [11:0] pc_next;
  logic        flip;
  logic        halt;
  logic        resume;
  logic        br_load;
  logic        br_add;
  logic [11:0] br_val;
  logic [11:0] pc;
  logic [11:0] pc_seq;
  logic [11:0] pc_br;
  logic        dir;
  logic        running;
  logic [15:0] step_cnt;
  logic        trap;
  modport master (
    output start, step, pc_next, flip, halt, resume, br_load, br_add, br_val,
    input  pc, pc_seq, pc_br, dir, running, step_cnt, trap
  );
  modport slave (
    input  start, step, pc_next, flip, halt, resume, br_load, br_add, br_val,
    output pc, pc_seq, pc_br, dir, running, step_cnt, trap
  );
endinterface

// File: rtl/pc_seq_stage.sv
// pc_seq_stage: reversible PC sequencer (IDLE/RUN/HALT) with branch register and step counter
// Optional wrap trap enabled by defining PC_WRAP_TRAP_EN.
module pc_seq_stage (
  input logic            clk,
  input logic            rst_n,
  pc_seq_stage_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  logic [1:0]  state, state_nxt;
  logic [11:0] pc, br, seq;
  logic [15:0] step_cnt;
  logic        dir, trap, commit, trip, resumed;
  assign seq     = dir ? pc - 12'd1 : pc + 12'd1;
  assign commit  = state == RUN && bus.step && !bus.halt;
  assign resumed = state == HALT && bus.resume && !bus.halt;
`ifdef PC_WRAP_TRAP_EN
  // A step that follows the sequential path across the 4095/0 boundary traps
  assign trip = commit && bus.pc_next == seq && (dir ? pc == 12'd0 : pc == 12'hfff);
`else
  assign trip = 1'b0;
`endif
  always_comb
    state_nxt = state == IDLE ? (bus.start ? RUN : IDLE) :
                state == RUN  ? ((bus.halt || trip) ? HALT : RUN) :
                resumed ? RUN : HALT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= 12'd0;
      br       <= 12'd0;
      dir      <= 1'b0;
      step_cnt <= 16'd0;
      trap     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (commit) begin
        pc       <= bus.pc_next;
        step_cnt <= dir ? step_cnt - 16'd1 : step_cnt + 16'd1;
      end
      if (state != IDLE) begin
        if (bus.flip) dir <= ~dir;
        if (bus.br_load) br <= bus.br_val;
        else if (bus.br_add) br <= dir ? br - bus.br_val : br + bus.br_val;
      end
      if (trip) trap <= 1'b1;
      else if (resumed) trap <= 1'b0;
    end
  end
  // Reset is synchronous, so the select inputs are forced while it is asserted
  assign bus.pc_seq   = !rst_n ? 12'd1 : seq;
  assign bus.pc_br    = !rst_n ? 12'd0 : (dir ? pc - br : pc + br);
  assign bus.pc       = pc;
  assign bus.dir      = dir;
  assign bus.running  = state == RUN;
  assign bus.step_cnt = step_cnt;
  assign bus.trap     = trap;
endmodule
